// File: rtl/pool_pkg.sv
// Shared types and helpers for the pooling layers.
package pool_pkg;

    typedef enum logic [2:0] {IDLE, READ, WAIT, EMIT, DONE} pool_state_t;

    localparam int unsigned POOL_TAPS = 4;
    localparam int unsigned SMAX_W    = 32;

    // Signed max; ties keep the first operand (the earlier tap).
    function automatic logic signed [SMAX_W-1:0] smax(
        input logic signed [SMAX_W-1:0] a,
        input logic signed [SMAX_W-1:0] b
    );
        return (b > a) ? b : a;
    endfunction

endpackage

// File: rtl/max_pool_reader_if.sv
// Conv-RAM read port, pooled-output stream and done handshake of max_pool_reader.
interface max_pool_reader_if #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned OUT_ADDR_W = 8
);
    logic                         conv_done;
    logic                         rd_en;
    logic [ADDR_W-1:0]            rd_addr;
    logic signed [DATA_W-1:0]     rd_data;
    logic                         out_valid;
    logic                         out_ready;
    logic signed [DATA_W-1:0]     out_data;
    logic [OUT_ADDR_W-1:0]        out_idx;
    logic                         done;

    modport master (
        input  conv_done, rd_data, out_ready,
        output rd_en, rd_addr, out_valid, out_data, out_idx, done
    );

    modport slave (
        output conv_done, rd_data, out_ready,
        input  rd_en, rd_addr, out_valid, out_data, out_idx, done
    );
endinterface

// File: rtl/pool_addr_gen.sv
// Row/column/tap counters for 2x2 stride-2 pooling; drives the RAM address and pooled index.
module pool_addr_gen
    import pool_pkg::*;
#(
    parameter int unsigned FMAP_W     = 26,
    parameter int unsigned FMAP_H     = 26,
    parameter int unsigned ADDR_W     = $clog2(FMAP_W*FMAP_H),
    parameter int unsigned OUT_ADDR_W = $clog2((FMAP_W/2)*(FMAP_H/2))
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  step,
    input  logic                  next_win,
    output logic [ADDR_W-1:0]     rd_addr,
    output logic [OUT_ADDR_W-1:0] out_idx,
    output logic                  first_tap_c,
    output logic                  last_tap_c,
    output logic                  last_win_c
);
    localparam int unsigned OW    = FMAP_W / 2;
    localparam int unsigned OH    = FMAP_H / 2;
    localparam int unsigned COL_W = (OW > 1) ? $clog2(OW) : 1;
    localparam int unsigned ROW_W = (OH > 1) ? $clog2(OH) : 1;
    localparam int unsigned TAP_W = $clog2(POOL_TAPS);

    logic [ROW_W-1:0]      row, row_n;
    logic [COL_W-1:0]      col, col_n;
    logic [TAP_W-1:0]      tap, tap_n;
    logic [OUT_ADDR_W-1:0] idx_n;
    logic [31:0]           addr_n;

    assign first_tap_c = (tap == '0);
    assign last_tap_c  = (tap == TAP_W'(POOL_TAPS - 1));
    assign last_win_c  = (row == ROW_W'(OH - 1)) && (col == COL_W'(OW - 1));

    // Tap order: base, base+1, base+FMAP_W, base+FMAP_W+1.
    always_comb begin
        row_n = row;
        col_n = col;
        tap_n = tap;
        idx_n = out_idx;
        if (start) begin
            row_n = '0;
            col_n = '0;
            tap_n = '0;
            idx_n = '0;
        end else if (next_win) begin
            tap_n = '0;
            idx_n = out_idx + OUT_ADDR_W'(1);
            if (col == COL_W'(OW - 1)) begin
                col_n = '0;
                row_n = row + ROW_W'(1);
            end else begin
                col_n = col + COL_W'(1);
            end
        end else if (step) begin
            tap_n = tap + TAP_W'(1);
        end
        addr_n = 32'(row_n) * 32'(2 * FMAP_W) + 32'(col_n) * 32'd2
               + (tap_n[1] ? 32'(FMAP_W) : 32'd0) + 32'(tap_n[0]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row     <= '0;
            col     <= '0;
            tap     <= '0;
            out_idx <= '0;
            rd_addr <= '0;
        end else begin
            row     <= row_n;
            col     <= col_n;
            tap     <= tap_n;
            out_idx <= idx_n;
            rd_addr <= ADDR_W'(addr_n);
        end
    end

endmodule

// File: rtl/max_pool_reader.sv
// 2x2 stride-2 max pooling over the conv output RAM, streamed one value per window.
// Define RELU_EN to clamp negative pooled values to zero on the way out.
module max_pool_reader
    import pool_pkg::*;
#(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned FMAP_W     = 26,
    parameter int unsigned FMAP_H     = 26,
    parameter int unsigned ADDR_W     = $clog2(FMAP_W*FMAP_H),
    parameter int unsigned OUT_ADDR_W = $clog2((FMAP_W/2)*(FMAP_H/2))
) (
    input  logic               clk,
    input  logic               rst,
    max_pool_reader_if.master  bus
);
    pool_state_t              state;
    logic                     rd_en_q, out_valid_q, done_q;
    logic                     pend_valid, pend_first;
    logic signed [DATA_W-1:0] acc, acc_next_c, relu_c, out_data_q;
    logic                     start_c, step_c, next_win_c;
    logic                     first_tap_c, last_tap_c, last_win_c;

    assign start_c    = (state == IDLE) && bus.conv_done;
    assign step_c     = (state == READ) && !last_tap_c;
    assign next_win_c = (state == EMIT) && bus.out_ready && !last_win_c;

    pool_addr_gen #(
        .FMAP_W     (FMAP_W),
        .FMAP_H     (FMAP_H),
        .ADDR_W     (ADDR_W),
        .OUT_ADDR_W (OUT_ADDR_W)
    ) u_addr_gen (
        .clk         (clk),
        .rst         (rst),
        .start       (start_c),
        .step        (step_c),
        .next_win    (next_win_c),
        .rd_addr     (bus.rd_addr),
        .out_idx     (bus.out_idx),
        .first_tap_c (first_tap_c),
        .last_tap_c  (last_tap_c),
        .last_win_c  (last_win_c)
    );

    // Tap-0 data loads the accumulator outright so a previous window never leaks in.
    always_comb begin
        acc_next_c = acc;
        if (pend_valid) begin
            acc_next_c = pend_first ? bus.rd_data
                                    : DATA_W'(smax(SMAX_W'(acc), SMAX_W'(bus.rd_data)));
        end
    end

`ifdef RELU_EN
    assign relu_c = acc_next_c[DATA_W-1] ? '0 : acc_next_c;
`else
    assign relu_c = acc_next_c;
`endif

    // pend_* track which tap the returning rd_data belongs to (1-cycle RAM latency).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            rd_en_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            done_q      <= 1'b0;
            acc         <= '0;
            pend_valid  <= 1'b0;
            pend_first  <= 1'b0;
        end else begin
            pend_valid <= rd_en_q;
            pend_first <= rd_en_q && first_tap_c;
            acc        <= acc_next_c;
            case (state)
                IDLE: begin
                    if (bus.conv_done) begin
                        state   <= READ;
                        rd_en_q <= 1'b1;
                    end
                end
                READ: begin
                    if (last_tap_c) begin
                        state   <= WAIT;
                        rd_en_q <= 1'b0;
                    end
                end
                WAIT: begin
                    state       <= EMIT;
                    out_valid_q <= 1'b1;
                    out_data_q  <= relu_c;
                end
                EMIT: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        if (last_win_c) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end else begin
                            state   <= READ;
                            rd_en_q <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (!bus.conv_done) begin
                        state  <= IDLE;
                        done_q <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.rd_en     = rd_en_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_max_pool_reader.sv
// Scoreboard bench for max_pool_reader: 4x4, 5x5 and 26x26 instances with RAM models.
module tb_max_pool_reader;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int inst;
        int idx;
        int data;
    } exp_t;
    exp_t expq[$];

    logic cdone [3];
    logic rdy   [3];
    logic mv    [3];
    logic men   [3];
    logic mdn   [3];
    int   md    [3];
    int   midx  [3];
    int   maddr [3];
    int   nout  [3] = '{0, 0, 0};

    logic signed [15:0] mem4  [16];
    logic signed [15:0] mem5  [25];
    logic signed [15:0] mem26 [676];
    bit                 read5 [32];

    int pat_mixed [16] = '{9, 2, 1, 8, 3, 4, 2, 3, 0, 1, -1, 100, 7, -5, -200, 99};
    int pat_neg   [16] = '{-3, -9, -20, -4, -1, -7, -5, -6,
                           -100, -100, -32768, -8, -100, -50, -9, -32767};
    int skip5     [7]  = '{4, 9, 20, 21, 22, 23, 24};

    max_pool_reader_if #(.DATA_W(16), .ADDR_W(4),  .OUT_ADDR_W(2)) b4  ();
    max_pool_reader_if #(.DATA_W(16), .ADDR_W(5),  .OUT_ADDR_W(2)) b5  ();
    max_pool_reader_if #(.DATA_W(16), .ADDR_W(10), .OUT_ADDR_W(8)) b26 ();

    max_pool_reader #(.DATA_W(16), .FMAP_W(4),  .FMAP_H(4))  u4  (.clk(clk), .rst(rst), .bus(b4));
    max_pool_reader #(.DATA_W(16), .FMAP_W(5),  .FMAP_H(5))  u5  (.clk(clk), .rst(rst), .bus(b5));
    max_pool_reader #(.DATA_W(16), .FMAP_W(26), .FMAP_H(26)) u26 (.clk(clk), .rst(rst), .bus(b26));

    // Conv output RAM models, one cycle read latency
    always @(posedge clk) if (b4.rd_en)  b4.rd_data  <= mem4[b4.rd_addr];
    always @(posedge clk) if (b5.rd_en)  b5.rd_data  <= mem5[b5.rd_addr];
    always @(posedge clk) if (b26.rd_en) b26.rd_data <= mem26[b26.rd_addr];
    always @(posedge clk) if (b5.rd_en)  read5[b5.rd_addr] <= 1'b1;

    assign b4.conv_done  = cdone[0];
    assign b5.conv_done  = cdone[1];
    assign b26.conv_done = cdone[2];
    assign b4.out_ready  = rdy[0];
    assign b5.out_ready  = rdy[1];
    assign b26.out_ready = rdy[2];

    assign mv[0] = b4.out_valid;   assign mv[1] = b5.out_valid;   assign mv[2] = b26.out_valid;
    assign men[0] = b4.rd_en;      assign men[1] = b5.rd_en;      assign men[2] = b26.rd_en;
    assign mdn[0] = b4.done;       assign mdn[1] = b5.done;       assign mdn[2] = b26.done;
    assign md[0] = int'(b4.out_data);
    assign md[1] = int'(b5.out_data);
    assign md[2] = int'(b26.out_data);
    assign midx[0] = int'(b4.out_idx);
    assign midx[1] = int'(b5.out_idx);
    assign midx[2] = int'(b26.out_idx);
    assign maddr[0] = int'(b4.rd_addr);
    assign maddr[1] = int'(b5.rd_addr);
    assign maddr[2] = int'(b26.rd_addr);

    task automatic chk(input string name, input int got, input int req);
        checks++;
        if (got != req) begin
            errors++;
            $display("FAIL %s got=%0d required=%0d", name, got, req);
        end
    endtask

    function automatic void push(input int k, input int idx, input int data);
        exp_t e;
        e.inst = k;
        e.idx  = idx;
        e.data = data;
        expq.push_back(e);
    endfunction

    // Pops one expected entry per accepted output of any instance.
    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                if (mv[k] && rdy[k]) begin
                    nout[k]++;
                    checks++;
                    if (expq.size() == 0) begin
                        errors++;
                        $display("FAIL out_unexpected inst=%0d got idx=%0d data=%0d required=no output",
                                 k, midx[k], md[k]);
                    end else begin
                        e = expq.pop_front();
                        if (e.inst != k || e.idx != midx[k] || e.data != md[k]) begin
                            errors++;
                            $display("FAIL out_stream got inst=%0d idx=%0d data=%0d required inst=%0d idx=%0d data=%0d",
                                     k, midx[k], md[k], e.inst, e.idx, e.data);
                        end
                    end
                end
            end
        end
    endtask

    // One full pass: raise conv_done, wait for done, check latency, drop conv_done.
    task automatic run_pass(input int k, input int exp_cyc);
        int  start;
        bit  seen;
        @(posedge clk);
        #1;
        cdone[k] = 1'b1;
        start    = cyc;
        seen     = 1'b0;
        for (int i = 0; i < 5000 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (mdn[k]) seen = 1'b1;
        end
        chk("done_seen", int'(seen), 1);
        if (seen && exp_cyc >= 0) chk("done_latency", cyc - start - 1, exp_cyc);
        chk("queue_drained", expq.size(), 0);
        cdone[k] = 1'b0;
        @(posedge clk);
        #1;
        chk("done_falls", int'(mdn[k]), 0);
    endtask

    // Holds out_ready low for 10 cycles of the first EMIT of instance 0.
    task automatic bp_check(input int exp_data);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (mv[0]) seen = 1'b1;
        end
        chk("bp_valid_seen", int'(seen), 1);
        for (int i = 0; i < 10; i++) begin
            chk("bp_valid", int'(mv[0]), 1);
            chk("bp_data", md[0], exp_data);
            chk("bp_idx", midx[0], 0);
            chk("bp_no_rd_en", int'(men[0]), 0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        rdy[0] = 1'b1;
    endtask

    task automatic chk_zero4(input string tag);
        chk({tag, "_rd_en"},     int'(men[0]), 0);
        chk({tag, "_rd_addr"},   maddr[0], 0);
        chk({tag, "_out_valid"}, int'(mv[0]), 0);
        chk({tag, "_out_data"},  md[0], 0);
        chk({tag, "_out_idx"},   midx[0], 0);
        chk({tag, "_done"},      int'(mdn[0]), 0);
    endtask

    task automatic push_ramp4();
        push(0, 0, 5);
        push(0, 1, 7);
        push(0, 2, 13);
        push(0, 3, 15);
    endtask

    initial begin
        bit found;
        for (int k = 0; k < 3; k++) begin
            cdone[k] = 1'b0;
            rdy[k]   = 1'b0;
        end
        for (int i = 0; i < 16; i++)  mem4[i]  = 16'(i);
        for (int i = 0; i < 25; i++)  mem5[i]  = 16'(i);
        for (int i = 0; i < 676; i++) mem26[i] = 16'(i);

        repeat (3) @(posedge clk);
        #1;
        chk_zero4("reset");
        chk("reset_done_26", int'(mdn[2]), 0);
        rst = 1'b0;

        fork
            monitor();
        join_none

        // Ramp 0..15: maxima sit on tap 3
        rdy[0] = 1'b1;
        push_ramp4();
        run_pass(0, 24);

        // Maxima on taps 0,1,2,1 with backpressure on the first window
        for (int i = 0; i < 16; i++) mem4[i] = 16'(pat_mixed[i]);
        rdy[0] = 1'b0;
        push(0, 0, 9);
        push(0, 1, 8);
        push(0, 2, 7);
        push(0, 3, 100);
        fork
            run_pass(0, -1);
            bp_check(9);
        join

        // All negative right after a window whose max was 100
        for (int i = 0; i < 16; i++) mem4[i] = 16'(pat_neg[i]);
`ifdef RELU_EN
        push(0, 0, 0);
        push(0, 1, 0);
        push(0, 2, 0);
        push(0, 3, 0);
`else
        push(0, 0, -1);
        push(0, 1, -4);
        push(0, 2, -50);
        push(0, 3, -8);
`endif
        run_pass(0, 24);

        // Reset during the second window's READ, then a clean restart
        for (int i = 0; i < 16; i++) mem4[i] = 16'(i);
        push_ramp4();
        @(posedge clk);
        #1;
        cdone[0] = 1'b1;
        found    = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(posedge clk);
            #1;
            if (men[0] && maddr[0] == 2) found = 1'b1;
        end
        chk("second_window_read", int'(found), 1);
        rst = 1'b1;
        #1;
        chk_zero4("midrst");
        expq.delete();
        cdone[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        push_ramp4();
        run_pass(0, 24);

        // Odd 5x5 map: last row and column are skipped
        rdy[1] = 1'b1;
        push(1, 0, 6);
        push(1, 1, 8);
        push(1, 2, 16);
        push(1, 3, 18);
        run_pass(1, 24);
        for (int i = 0; i < 7; i++) chk($sformatf("skip_addr_%0d", skip5[i]), int'(read5[skip5[i]]), 0);
        chk("count_5x5", nout[1], 4);

        // Full 26x26 map, ramp then reversed ramp as a second pass
        rdy[2] = 1'b1;
        for (int r = 0; r < 13; r++)
            for (int c = 0; c < 13; c++)
                push(2, r * 13 + c, 52 * r + 2 * c + 27);
        run_pass(2, 1014);
        chk("count_26_pass1", nout[2], 169);

        for (int i = 0; i < 676; i++) mem26[i] = 16'(1000 - i);
        for (int r = 0; r < 13; r++)
            for (int c = 0; c < 13; c++)
                push(2, r * 13 + c, 1000 - (52 * r + 2 * c));
        run_pass(2, 1014);
        chk("count_26_pass2", nout[2], 338);
        chk("last_idx_26", midx[2], 168);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
